// File: rtl/burst_cmd_gen_if.sv
// Command/response bus between burst_cmd_gen (master) and the memory-master
// datapath (slave): read/write burst commands plus write-burst completions.
interface burst_cmd_gen_if;
  logic        rd_cmd_valid;
  logic        rd_cmd_ready;
  logic [31:0] rd_cmd_addr;
  logic [7:0]  rd_cmd_len;

  logic        wr_cmd_valid;
  logic        wr_cmd_ready;
  logic [31:0] wr_cmd_addr;
  logic [7:0]  wr_cmd_len;

  logic        wr_resp_valid;
  logic        wr_resp_ready;

  modport master (
    output rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
    input  rd_cmd_ready,
    output wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
    input  wr_cmd_ready,
    input  wr_resp_valid,
    output wr_resp_ready
  );

  modport slave (
    input  rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
    output rd_cmd_ready,
    input  wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
    output wr_cmd_ready,
    output wr_resp_valid,
    input  wr_resp_ready
  );
endinterface

// File: rtl/burst_cmd_gen.sv
// Splits a byte-length transfer into read and write burst commands and tracks
// write-burst completions. Define BURST_CMD_GEN_4K_SPLIT_EN to stop bursts crossing 4 KiB.
module burst_cmd_gen #(
  parameter int unsigned BEAT_BYTES      = 64,
  parameter int unsigned MAX_BURST_BEATS = 64
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   user_start,
  input  logic [31:0]            byte_len,
  input  logic [31:0]            src_addr,
  input  logic [31:0]            dst_addr,
  output logic                   user_done,
  output logic                   user_idle,
  burst_cmd_gen_if.master        cmd
);

  localparam int unsigned SH = $clog2(BEAT_BYTES);
  localparam logic [31:0] ALIGN_MASK = ~(32'(BEAT_BYTES) - 32'd1);
  localparam logic [31:0] MAX_BEATS  = 32'(MAX_BURST_BEATS);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_RESP = 2'd2;
  localparam logic [1:0] S_DONE      = 2'd3;

  logic [1:0]  state_reg;
  logic [1:0]  state_next;
  logic        start_q;
  logic        start_accept;
  logic        issuing;
  logic [31:0] beats_total;
  logic [31:0] wr_issued_reg;
  logic [31:0] wr_acked_reg;
  logic [31:0] wr_acked_next;
  logic        resp_hs;
  logic        wr_load;

  // Channel 0 is read, channel 1 is write.
  logic [31:0] chan_base     [2];
  logic [31:0] chan_cmd_addr [2];
  logic [7:0]  chan_cmd_len  [2];
  logic [1:0]  chan_ready;
  logic [1:0]  chan_valid;
  logic [1:0]  chan_drained;

  assign chan_base[0] = src_addr & ALIGN_MASK;
  assign chan_base[1] = dst_addr & ALIGN_MASK;
  assign chan_ready   = {cmd.wr_cmd_ready, cmd.rd_cmd_ready};

  // Ceiling division without a 32-bit overflow on byte_len near 2^32.
  assign beats_total  = (byte_len >> SH) + {31'd0, |(byte_len & ~ALIGN_MASK)};

  assign issuing      = (state_reg == S_ISSUE);
  assign start_accept = (state_reg == S_IDLE) && user_start && !start_q;
  assign resp_hs      = cmd.wr_resp_valid && cmd.wr_resp_ready;
  assign wr_acked_next = wr_acked_reg + {31'd0, resp_hs};

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic [31:0] addr_reg;
    logic [31:0] remaining_reg;
    logic [31:0] cmd_addr_reg;
    logic [7:0]  cmd_len_reg;
    logic        valid_reg;
    logic [31:0] burst;
    logic        load;
`ifdef BURST_CMD_GEN_4K_SPLIT_EN
    logic [12:0] bytes_to_4k;
    logic [31:0] beats_to_4k;

    assign bytes_to_4k = 13'd4096 - {1'b0, addr_reg[11:0]};
    assign beats_to_4k = 32'(bytes_to_4k >> SH);
`endif

    always_comb begin
      burst = remaining_reg;
      if (burst > MAX_BEATS) begin
        burst = MAX_BEATS;
      end
`ifdef BURST_CMD_GEN_4K_SPLIT_EN
      if (burst > beats_to_4k) begin
        burst = beats_to_4k;
      end
`endif
    end

    // A new command may replace the current one in the same cycle it is accepted.
    assign load = issuing && (remaining_reg != 32'd0) && (!valid_reg || chan_ready[gi]);

    always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
        addr_reg      <= 32'd0;
        remaining_reg <= 32'd0;
        cmd_addr_reg  <= 32'd0;
        cmd_len_reg   <= 8'd0;
        valid_reg     <= 1'b0;
      end else if (start_accept) begin
        addr_reg      <= chan_base[gi];
        remaining_reg <= beats_total;
        valid_reg     <= 1'b0;
      end else if (load) begin
        cmd_addr_reg  <= addr_reg;
        cmd_len_reg   <= 8'(burst - 32'd1);
        valid_reg     <= 1'b1;
        addr_reg      <= addr_reg + (burst << SH);
        remaining_reg <= remaining_reg - burst;
      end else if (valid_reg && chan_ready[gi]) begin
        valid_reg     <= 1'b0;
      end
    end

    assign chan_valid[gi]    = valid_reg;
    assign chan_cmd_addr[gi] = cmd_addr_reg;
    assign chan_cmd_len[gi]  = cmd_len_reg;
    assign chan_drained[gi]  = (remaining_reg == 32'd0) && (!valid_reg || chan_ready[gi]);

    if (gi == 1) begin : g_wr_load
      assign wr_load = load;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_accept) begin
          state_next = (byte_len == 32'd0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Late responses may already have caught up, so skip WAIT_RESP when they have.
        if (&chan_drained) begin
          state_next = (wr_acked_next == wr_issued_reg) ? S_DONE : S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        if (wr_acked_next == wr_issued_reg) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg     <= S_IDLE;
      start_q       <= 1'b0;
      wr_issued_reg <= 32'd0;
      wr_acked_reg  <= 32'd0;
    end else begin
      state_reg <= state_next;
      start_q   <= user_start;
      if (start_accept) begin
        wr_issued_reg <= 32'd0;
        wr_acked_reg  <= 32'd0;
      end else begin
        if (wr_load) begin
          wr_issued_reg <= wr_issued_reg + 32'd1;
        end
        if (resp_hs) begin
          wr_acked_reg <= wr_acked_next;
        end
      end
    end
  end

  assign user_idle         = (state_reg == S_IDLE);
  assign user_done         = (state_reg == S_DONE);
  assign cmd.wr_resp_ready = (state_reg == S_ISSUE) || (state_reg == S_WAIT_RESP);

  assign cmd.rd_cmd_valid = chan_valid[0];
  assign cmd.rd_cmd_addr  = chan_cmd_addr[0];
  assign cmd.rd_cmd_len   = chan_cmd_len[0];
  assign cmd.wr_cmd_valid = chan_valid[1];
  assign cmd.wr_cmd_addr  = chan_cmd_addr[1];
  assign cmd.wr_cmd_len   = chan_cmd_len[1];

endmodule

// File: tb/tb_burst_cmd_gen.sv
// Randomised bench for burst_cmd_gen: a transfer-level model plans the burst
// lists and cycle-level handshake expectations, checked every cycle.
`timescale 1ns/1ps
module tb_burst_cmd_gen;

  localparam int BB   = 64;
  localparam int MAXB = 64;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } cmd_t;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        user_start = 1'b0;
  logic [31:0] byte_len = 32'd0;
  logic [31:0] src_addr = 32'd0;
  logic [31:0] dst_addr = 32'd0;
  logic        user_done;
  logic        user_idle;

  burst_cmd_gen_if bus ();

  burst_cmd_gen #(.BEAT_BYTES(BB), .MAX_BURST_BEATS(MAXB)) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .user_start (user_start),
    .byte_len   (byte_len),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .user_done  (user_done),
    .user_idle  (user_idle),
    .cmd        (bus.master)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  cmd_t rd_q[$];
  cmd_t wr_q[$];
  cmd_t act_rd[$];
  cmd_t act_wr[$];
  int   phase = 0;            // 0 idle, 1 busy, 2 done pulse
  int   busy_cyc = 0;
  int   resp_cnt = 0;
  int   wr_total = 0;
  int   owed = 0;
  bit   prev_start = 0;
  int   cyc_cnt = 0;
  int   start_cyc = 0;
  int   first_rv_cyc = -1;
  int   done_cyc = 0;
  int   done_cnt = 0;
  int   resp_at_done = 0;
  int   resp_before_wr2 = -1;
  bit   done_seen = 0;
  bit   rd_hold = 0;
  bit   wr_hold = 0;
  cmd_t rd_hold_c;
  cmd_t wr_hold_c;
  int   rd_hold_cnt = 0;

  // stimulus modes
  int rd_mode = 0;
  int wr_mode = 0;
  int resp_mode = 0;
  int drv_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Burst list straight from the splitting rules.
  function automatic void plan(input int ch, input logic [31:0] base);
    logic [31:0] a;
    longint      rem;
    longint      b;
    cmd_t        c;
`ifdef BURST_CMD_GEN_4K_SPLIT_EN
    longint      room;
`endif
    a   = base & ~32'(BB - 1);
    rem = (longint'(byte_len) + BB - 1) / BB;
    while (rem > 0) begin
      b = (rem < MAXB) ? rem : MAXB;
`ifdef BURST_CMD_GEN_4K_SPLIT_EN
      room = (4096 - longint'(a % 4096)) / BB;
      if (room < b) b = room;
`endif
      c.addr = a;
      c.len  = 8'(b - 1);
      if (ch == 0) rd_q.push_back(c);
      else         wr_q.push_back(c);
      a   = a + 32'(b * BB);
      rem = rem - b;
    end
  endfunction

  always @(negedge ACLK) begin
    cmd_t c;
    cyc_cnt++;
    if (!ARESETN) begin
      phase = 0; rd_q.delete(); wr_q.delete(); owed = 0; prev_start = 0;
      rd_hold = 0; wr_hold = 0; resp_cnt = 0; busy_cyc = 0;
    end else begin
      chk("user_idle", user_idle, phase == 0);
      chk("user_done", user_done, phase == 2);
      chk("wr_resp_ready", bus.wr_resp_ready, phase == 1);
      chk("rd_cmd_valid", bus.rd_cmd_valid, (phase == 1) && (busy_cyc >= 1) && (rd_q.size() > 0));
      chk("wr_cmd_valid", bus.wr_cmd_valid, (phase == 1) && (busy_cyc >= 1) && (wr_q.size() > 0));
      if (rd_hold) begin
        rd_hold_cnt++;
        chk("rd_hold_valid", bus.rd_cmd_valid, 1);
        chk("rd_hold_fields", {bus.rd_cmd_addr, bus.rd_cmd_len}, {rd_hold_c.addr, rd_hold_c.len});
      end
      if (wr_hold) begin
        chk("wr_hold_valid", bus.wr_cmd_valid, 1);
        chk("wr_hold_fields", {bus.wr_cmd_addr, bus.wr_cmd_len}, {wr_hold_c.addr, wr_hold_c.len});
      end
      if (bus.rd_cmd_valid && bus.rd_cmd_ready) begin
        c.addr = bus.rd_cmd_addr; c.len = bus.rd_cmd_len;
        act_rd.push_back(c);
        if (rd_q.size() == 0) chk("rd_unexpected_cmd", 1, 0);
        else begin
          chk("rd_cmd", {c.addr, c.len}, {rd_q[0].addr, rd_q[0].len});
          void'(rd_q.pop_front());
        end
      end
      rd_hold = bus.rd_cmd_valid && !bus.rd_cmd_ready;
      rd_hold_c.addr = bus.rd_cmd_addr; rd_hold_c.len = bus.rd_cmd_len;
      if (bus.wr_cmd_valid && bus.wr_cmd_ready) begin
        c.addr = bus.wr_cmd_addr; c.len = bus.wr_cmd_len;
        act_wr.push_back(c);
        if (act_wr.size() == 2) resp_before_wr2 = resp_cnt;
        owed++;
        if (wr_q.size() == 0) chk("wr_unexpected_cmd", 1, 0);
        else begin
          chk("wr_cmd", {c.addr, c.len}, {wr_q[0].addr, wr_q[0].len});
          void'(wr_q.pop_front());
        end
      end
      wr_hold = bus.wr_cmd_valid && !bus.wr_cmd_ready;
      wr_hold_c.addr = bus.wr_cmd_addr; wr_hold_c.len = bus.wr_cmd_len;
      if (bus.wr_resp_valid && bus.wr_resp_ready) begin
        resp_cnt++;
        owed--;
      end
      if (user_done) begin
        done_cnt++; done_seen = 1; done_cyc = cyc_cnt; resp_at_done = resp_cnt;
      end
      if (bus.rd_cmd_valid && first_rv_cyc < 0) first_rv_cyc = cyc_cnt;
      case (phase)
        0: if (user_start && !prev_start) begin
             rd_q.delete(); wr_q.delete();
             plan(0, src_addr); plan(1, dst_addr);
             wr_total = wr_q.size(); resp_cnt = 0; busy_cyc = 0;
             start_cyc = cyc_cnt; first_rv_cyc = -1;
             phase = (byte_len == 0) ? 2 : 1;
           end
        1: begin
             busy_cyc++;
             if (rd_q.size() == 0 && wr_q.size() == 0 && resp_cnt == wr_total) phase = 2;
           end
        default: phase = 0;
      endcase
      prev_start = user_start;
    end
  end

  // Downstream behaviour: ready patterns and write responses for accepted bursts.
  always @(posedge ACLK) begin
    #1;
    drv_cyc++;
    case (rd_mode)
      0:       bus.rd_cmd_ready = 1'b1;
      1:       bus.rd_cmd_ready = 1'($urandom_range(0, 1));
      default: bus.rd_cmd_ready = (drv_cyc > 6) && (drv_cyc % 2 == 0);
    endcase
    case (wr_mode)
      0:       bus.wr_cmd_ready = 1'b1;
      1:       bus.wr_cmd_ready = 1'($urandom_range(0, 1));
      default: bus.wr_cmd_ready = (act_wr.size() == 0) || (resp_cnt >= 1);
    endcase
    if (!ARESETN) bus.wr_resp_valid = 1'b0;
    else bus.wr_resp_valid = (owed > 0) && ((resp_mode == 0) || ($urandom_range(0, 2) != 0));
  end

  task automatic run_xfer(input string tag, input logic [31:0] len, input logic [31:0] s,
                          input logic [31:0] d, input int rm, input int wm, input int pm);
    int i;
    @(posedge ACLK); #2;
    byte_len = len; src_addr = s; dst_addr = d;
    rd_mode = rm; wr_mode = wm; resp_mode = pm;
    act_rd.delete(); act_wr.delete();
    done_seen = 0; done_cnt = 0; resp_before_wr2 = -1; drv_cyc = 0; rd_hold_cnt = 0;
    user_start = 1'b1;
    i = 0;
    while (!done_seen && i < 3000) begin
      @(negedge ACLK);
      i++;
    end
    chk({tag, "_done_seen"}, done_seen, 1);
    @(posedge ACLK); #2;
    user_start = 1'b0;
    repeat (2) @(posedge ACLK);
    chk({tag, "_single_done"}, done_cnt, 1);
    chk({tag, "_rd_left"}, rd_q.size(), 0);
    chk({tag, "_wr_left"}, wr_q.size(), 0);
    $display("run %s: len=%0d src=%h dst=%h rd_cmds=%0d wr_cmds=%0d resps=%0d done_pulses=%0d",
             tag, len, s, d, act_rd.size(), act_wr.size(), resp_at_done, done_cnt);
  endtask

  task automatic check_basic(input string tag);
    logic [39:0] er[$];
    logic [39:0] ew[$];
    er = '{{32'h1000, 8'd63}, {32'h2000, 8'd63}, {32'h3000, 8'd28}};
`ifdef BURST_CMD_GEN_4K_SPLIT_EN
    ew = '{{32'h0F80, 8'd1}, {32'h1000, 8'd63}, {32'h2000, 8'd63}, {32'h3000, 8'd26}};
`else
    ew = '{{32'h0F80, 8'd63}, {32'h1F80, 8'd63}, {32'h2F80, 8'd28}};
`endif
    chk({tag, "_rd_count"}, act_rd.size(), er.size());
    for (int i = 0; i < er.size(); i++)
      if (i < act_rd.size()) chk($sformatf("%s_rd%0d", tag, i), {act_rd[i].addr, act_rd[i].len}, er[i]);
    chk({tag, "_wr_count"}, act_wr.size(), ew.size());
    for (int i = 0; i < ew.size(); i++)
      if (i < act_wr.size()) chk($sformatf("%s_wr%0d", tag, i), {act_wr[i].addr, act_wr[i].len}, ew[i]);
    chk({tag, "_resps_at_done"}, resp_at_done, ew.size());
    chk({tag, "_valid_latency"}, first_rv_cyc - start_cyc, 2);
  endtask

  initial begin
    logic [31:0] len;
    logic [31:0] s;
    logic [31:0] d;
    bus.rd_cmd_ready = 1'b0;
    bus.wr_cmd_ready = 1'b0;
    bus.wr_resp_valid = 1'b0;
    #12;
    chk("rst_idle", user_idle, 1);
    chk("rst_done", user_done, 0);
    chk("rst_rd_valid", bus.rd_cmd_valid, 0);
    chk("rst_wr_valid", bus.wr_cmd_valid, 0);
    chk("rst_resp_ready", bus.wr_resp_ready, 0);
    chk("rst_rd_fields", {bus.rd_cmd_addr, bus.rd_cmd_len}, 0);
    chk("rst_wr_fields", {bus.wr_cmd_addr, bus.wr_cmd_len}, 0);
    @(posedge ACLK); #3;
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);

    run_xfer("basic", 32'd10000, 32'h1000, 32'h0F80, 0, 0, 0);
    check_basic("basic");

    run_xfer("backpressure", 32'd512, 32'h0, 32'h0, 2, 0, 0);
    chk("bp_rd_count", act_rd.size(), 1);
    if (act_rd.size() > 0) chk("bp_rd_cmd", {act_rd[0].addr, act_rd[0].len}, {32'h0, 8'd7});
    chk("bp_was_held", rd_hold_cnt >= 3, 1);

    run_xfer("early_resp", 32'd8192, 32'h4000, 32'h0, 0, 2, 0);
    chk("early_wr_count", act_wr.size(), 2);
    if (act_wr.size() == 2) begin
      chk("early_wr0", {act_wr[0].addr, act_wr[0].len}, {32'h0, 8'd63});
      chk("early_wr1", {act_wr[1].addr, act_wr[1].len}, {32'h1000, 8'd63});
    end
    chk("early_resp_before_wr2", resp_before_wr2, 1);
    chk("early_resps_at_done", resp_at_done, 2);

    // zero length with the start level held
    @(posedge ACLK); #2;
    byte_len = 32'd0; act_rd.delete(); act_wr.delete(); done_cnt = 0;
    user_start = 1'b1;
    repeat (12) @(negedge ACLK);
    chk("zl_done_latency", done_cyc - start_cyc, 1);
    chk("zl_no_retrigger", done_cnt, 1);
    chk("zl_no_cmds", act_rd.size() + act_wr.size(), 0);
    @(posedge ACLK); #2; user_start = 1'b0;
    @(posedge ACLK); #2; user_start = 1'b1;
    repeat (4) @(negedge ACLK);
    chk("zl_retrigger", done_cnt, 2);
    @(posedge ACLK); #2; user_start = 1'b0;
    repeat (2) @(posedge ACLK);
    $display("run zero_len: done_pulses=%0d", done_cnt);

    // reset in the middle of ISSUE
    @(posedge ACLK); #2;
    byte_len = 32'd20000; src_addr = 32'h100; dst_addr = 32'h8000;
    rd_mode = 1; wr_mode = 1; resp_mode = 1; act_rd.delete(); act_wr.delete();
    user_start = 1'b1;
    repeat (6) @(posedge ACLK);
    #1;
    chk("mid_busy", user_idle, 0);
    #2;
    ARESETN = 1'b0;
    #1;
    chk("mid_rst_rd_valid", bus.rd_cmd_valid, 0);
    chk("mid_rst_wr_valid", bus.wr_cmd_valid, 0);
    chk("mid_rst_idle", user_idle, 1);
    chk("mid_rst_resp_ready", bus.wr_resp_ready, 0);
    user_start = 1'b0;
    repeat (2) @(posedge ACLK);
    #3; ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);
    $display("run mid_reset: valids dropped, idle=%0b", user_idle);
    run_xfer("after_reset", 32'd10000, 32'h1000, 32'h0F80, 0, 0, 0);
    check_basic("after_reset");

    for (int r = 0; r < 25; r++) begin
      len = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 30000));
      s = $urandom;
      d = $urandom;
      if ($urandom_range(0, 3) == 0) s = 32'hFFFF_F000 | (s & 32'hFFF);
      if ($urandom_range(0, 3) == 0) d = 32'hFFFF_F000 | (d & 32'hFFF);
      run_xfer($sformatf("rand%0d", r), len, s, d,
               $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
